// File: rtl/onewire_temp_if.sv
// onewire_temp_if: bus-side signals between the 1-Wire responder and its pad/host logic
interface onewire_temp_if;
  logic dq_in;
  logic dq_oe;
  logic [15:0] temp_data;
  logic conv_req;
  logic cmd_err;
  logic busy;
  modport slave (input dq_in, temp_data, output dq_oe, conv_req, cmd_err, busy);
  modport master (output dq_in, temp_data, input dq_oe, conv_req, cmd_err, busy);
endinterface

// File: rtl/onewire_temp_slave.sv
// onewire_temp_slave: DS18B20-style 1-Wire responder (presence, SKIP ROM, CONVERT T, READ SCRATCHPAD word)
module onewire_temp_slave #(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int RST_MIN_US = 400,
  parameter int PD_WAIT_US = 30,
  parameter int PD_LEN_US = 120,
  parameter int SAMPLE_US = 30,
  parameter int TX_HOLD_US = 30
) (
  input logic sys_clk,
  input logic sys_rst_n,
  onewire_temp_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PD_WAIT, PD_DRIVE, ROM_CMD, FUNC_CMD, TX} state_t;
  localparam int PW = CLK_FREQ_MHZ > 1 ? $clog2(CLK_FREQ_MHZ) : 1;
  state_t state, state_n;
  logic dq_s1, dq_s2, dq_d;
  logic [1:0] rel_cnt;
  logic [PW-1:0] presc;
  logic [9:0] slot_us;
  logic slot_pend, tx_drive, tx_drive_n;
  logic [2:0] bit_cnt;
  logic [7:0] rx_byte, byte_n;
  logic [15:0] tx_shift;
  logic [4:0] tx_cnt;
  logic quiet, mfall, rst_rise, us_tick, sample, byte_done, pd_go, clr, conv_n, err_n;
  // Edges are only trusted once our own drive has been off long enough to clear the synchroniser.
  assign quiet = !bus.dq_oe && rel_cnt == 2'd3;
  assign mfall = quiet && dq_d && !dq_s2;
  assign rst_rise = quiet && !dq_d && dq_s2 && slot_us >= 10'(RST_MIN_US);
  assign us_tick = presc == PW'(CLK_FREQ_MHZ - 1);
  assign sample = slot_pend && slot_us == 10'(SAMPLE_US) && (state == ROM_CMD || state == FUNC_CMD);
  assign byte_n = {dq_s2, rx_byte[7:1]};
  assign byte_done = sample && bit_cnt == 3'd7;
  assign pd_go = state == PD_WAIT && slot_us == 10'(PD_WAIT_US);
  // The us timebase also restarts at reset release and presence start so it can time those phases.
  assign clr = mfall || rst_rise || pd_go;
  always_comb begin
    state_n = state;
    conv_n = 1'b0;
    err_n = 1'b0;
    if (rst_rise) state_n = PD_WAIT;
    else if (pd_go) state_n = PD_DRIVE;
    else if (state == PD_DRIVE && slot_us == 10'(PD_LEN_US)) state_n = ROM_CMD;
    else if (byte_done && state == ROM_CMD) begin
      state_n = byte_n == 8'hCC ? FUNC_CMD : IDLE;
      err_n = byte_n != 8'hCC;
    end else if (byte_done) begin
      state_n = byte_n == 8'hBE ? TX : IDLE;
      conv_n = byte_n == 8'h44;
      err_n = byte_n != 8'h44 && byte_n != 8'hBE;
    end else if (state == TX && tx_cnt == 5'd16 && !tx_drive) state_n = IDLE;
    tx_drive_n = rst_rise ? 1'b0 :
                 (state == TX && mfall && tx_cnt != 5'd16) ? !tx_shift[0] :
                 slot_us >= 10'(TX_HOLD_US) ? 1'b0 : tx_drive;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      {dq_s1, dq_s2, dq_d} <= 3'b000;
      rel_cnt <= 2'd0;
      presc <= '0;
      slot_us <= 10'd0;
      slot_pend <= 1'b0;
      bit_cnt <= 3'd0;
      rx_byte <= 8'd0;
      tx_shift <= 16'd0;
      tx_cnt <= 5'd0;
      tx_drive <= 1'b0;
      bus.dq_oe <= 1'b0;
      bus.conv_req <= 1'b0;
      bus.cmd_err <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      {dq_s1, dq_s2, dq_d} <= {bus.dq_in, dq_s1, dq_s2};
      rel_cnt <= bus.dq_oe ? 2'd0 : rel_cnt == 2'd3 ? rel_cnt : rel_cnt + 2'd1;
      presc <= (clr || us_tick) ? '0 : presc + PW'(1);
      slot_us <= clr ? 10'd0 : (us_tick && slot_us != 10'd1023) ? slot_us + 10'd1 : slot_us;
      slot_pend <= rst_rise ? 1'b0 : mfall ? 1'b1 : sample ? 1'b0 : slot_pend;
      bit_cnt <= state_n != state ? 3'd0 : sample ? bit_cnt + 3'd1 : bit_cnt;
      rx_byte <= sample ? byte_n : rx_byte;
      // The drive decision is latched from bit 0 at slot start, so the shift can happen immediately.
      tx_shift <= (state_n == TX && state != TX) ? bus.temp_data :
                  (state == TX && mfall) ? tx_shift >> 1 : tx_shift;
      tx_cnt <= state != TX ? 5'd0 : (mfall && tx_cnt != 5'd16) ? tx_cnt + 5'd1 : tx_cnt;
      tx_drive <= tx_drive_n;
      bus.dq_oe <= state_n == PD_DRIVE || tx_drive_n;
      bus.conv_req <= conv_n;
      bus.cmd_err <= err_n;
      bus.busy <= state_n != IDLE;
    end
endmodule

// File: tb/tb_onewire_temp_slave.sv
// tb_onewire_temp_slave: emulates a 1-Wire master on a wired-AND bus and checks the responder
module tb_onewire_temp_slave;
  localparam int CLK = 4;
  typedef struct packed {
    logic [7:0] rom;
    logic [7:0] func;
    logic [15:0] temp;
    int conv;
    int err;
    logic [15:0] rd;
  } vec_t;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b1;
  logic m_low = 1'b0;
  int checks = 0, errors = 0, conv_cnt = 0, err_cnt = 0, both_cnt = 0;
  vec_t vt [4];
  onewire_temp_if bus();
  assign bus.dq_in = !(m_low || bus.dq_oe);
  onewire_temp_slave #(.CLK_FREQ_MHZ(CLK)) dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
  always #5 sys_clk = !sys_clk;
  always @(negedge sys_clk) begin
    if (bus.conv_req) conv_cnt++;
    if (bus.cmd_err) err_cnt++;
    if (bus.conv_req && bus.cmd_err) both_cnt++;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end
  task automatic check(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d..%0d", name, act, act, lo, hi);
    end
  endtask
  task automatic us(input int n);
    repeat (n * CLK) @(negedge sys_clk);
  endtask
  // Transaction-level expectation: what the host should see for a ROM byte, function byte and temperature.
  function automatic void model(input logic [7:0] rom, func, input logic [15:0] t,
                                output int conv, err, output logic [15:0] rd);
    conv = 0;
    err = 0;
    rd = 16'hFFFF;
    if (rom != 8'hCC) err = 1;
    else if (func == 8'h44) conv = 1;
    else if (func == 8'hBE) rd = t;
    else err = 1;
  endfunction
  task automatic reset_pulse(input string tag);
    int dly, len, bsy;
    m_low = 1'b1;
    us(480);
    m_low = 1'b0;
    dly = 0;
    while (!bus.dq_oe && dly < 100 * CLK) begin
      @(negedge sys_clk);
      dly++;
    end
    bsy = int'(bus.busy);
    len = 0;
    while (bus.dq_oe && len < 200 * CLK) begin
      @(negedge sys_clk);
      len++;
    end
    check({tag, " pd_delay"}, dly, 29 * CLK, 31 * CLK);
    check({tag, " pd_busy"}, bsy, 1, 1);
    check({tag, " pd_len"}, len, 119 * CLK, 121 * CLK);
    us(5);
  endtask
  task automatic write_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      m_low = 1'b1;
      us(b[i] ? 15 : 60);
      m_low = 1'b0;
      us(b[i] ? 65 : 20);
    end
  endtask
  task automatic read_slot(output logic v, output int low);
    low = 0;
    v = 1'b0;
    m_low = 1'b1;
    for (int i = 1; i <= 50 * CLK; i++) begin
      @(negedge sys_clk);
      if (i == 2 * CLK) m_low = 1'b0;
      if (i == 15 * CLK) v = bus.dq_in;
      if (!bus.dq_in) low++;
    end
  endtask
  task automatic run_txn(input string tag, input logic [7:0] rom, func, input logic [15:0] temp,
                         input int exp_conv, exp_err, input logic [15:0] exp_rd);
    int c0, e0, low, lo_min, lo_max, hi_max, n;
    logic v;
    logic [15:0] rd;
    bus.temp_data = temp;
    reset_pulse(tag);
    c0 = conv_cnt;
    e0 = err_cnt;
    write_byte(rom);
    if (rom == 8'hCC) write_byte(func);
    n = (rom == 8'hCC && func == 8'hBE) ? 17 : 2;
    rd = 16'hFFFF;
    lo_min = 1000 * CLK;
    lo_max = 0;
    hi_max = 0;
    for (int i = 0; i < n; i++) begin
      read_slot(v, low);
      if (i < 16) rd[i] = v;
      else check({tag, " slot17"}, int'(v), 1, 1);
      if (v) hi_max = low > hi_max ? low : hi_max;
      else begin
        lo_min = low < lo_min ? low : lo_min;
        lo_max = low > lo_max ? low : lo_max;
      end
    end
    us(5);
    check({tag, " read_word"}, int'(rd), int'(exp_rd), int'(exp_rd));
    check({tag, " one_bit_low"}, hi_max, 0, 3 * CLK);
    if (lo_max > 0) begin
      check({tag, " zero_low_min"}, lo_min, 29 * CLK, 31 * CLK);
      check({tag, " zero_low_max"}, lo_max, 29 * CLK, 31 * CLK);
    end
    check({tag, " conv_pulses"}, conv_cnt - c0, exp_conv, exp_conv);
    check({tag, " err_pulses"}, err_cnt - e0, exp_err, exp_err);
    check({tag, " busy_end"}, int'(bus.busy), 0, 0);
  endtask
  initial begin
    logic [7:0] rom, func;
    logic [15:0] t, er;
    logic v;
    int ec, ee, n, low;
    vt[0] = '{8'hCC, 8'h44, 16'h1234, 1, 0, 16'hFFFF};
    vt[1] = '{8'hCC, 8'hBE, 16'h0191, 0, 0, 16'h0191};
    vt[2] = '{8'h33, 8'h44, 16'h0000, 0, 1, 16'hFFFF};
    vt[3] = '{8'hCC, 8'h55, 16'h0000, 0, 1, 16'hFFFF};
    bus.temp_data = 16'h0000;
    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst dq_oe", int'(bus.dq_oe), 0, 0);
    check("rst busy", int'(bus.busy), 0, 0);
    check("rst conv_req", int'(bus.conv_req), 0, 0);
    check("rst cmd_err", int'(bus.cmd_err), 0, 0);
    sys_rst_n = 1'b1;
    us(5);
    m_low = 1'b1;
    us(100);
    m_low = 1'b0;
    n = 0;
    for (int i = 0; i < 60 * CLK; i++) begin
      @(negedge sys_clk);
      if (bus.dq_oe || bus.busy) n++;
    end
    check("short_low no_presence", n, 0, 0);
    for (int i = 0; i < 4; i++)
      run_txn($sformatf("vec%0d", i), vt[i].rom, vt[i].func, vt[i].temp, vt[i].conv, vt[i].err, vt[i].rd);
    for (int k = 0; k < 2; k++) begin
      rom = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hCC;
      case ($urandom_range(0, 2))
        0: func = 8'h44;
        1: func = 8'hBE;
        default: func = 8'($urandom);
      endcase
      t = 16'($urandom);
      model(rom, func, t, ec, ee, er);
      run_txn($sformatf("rand%0d", k), rom, func, t, ec, ee, er);
    end
    m_low = 1'b1;
    us(480);
    m_low = 1'b0;
    n = 0;
    while (!bus.dq_oe && n < 100 * CLK) begin
      @(negedge sys_clk);
      n++;
    end
    us(20);
    check("async pre_oe", int'(bus.dq_oe), 1, 1);
    sys_rst_n = 1'b0;
    #1;
    check("async dq_oe", int'(bus.dq_oe), 0, 0);
    check("async busy", int'(bus.busy), 0, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    us(5);
    t = 16'($urandom);
    bus.temp_data = t;
    reset_pulse("abort");
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 5; i++) begin
      read_slot(v, low);
      check($sformatf("abort bit%0d", i), int'(v), int'(t[i]), int'(t[i]));
    end
    run_txn("after_abort", 8'hCC, 8'h44, t, 1, 0, 16'hFFFF);
    check("conv_and_err_overlap", both_cnt, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
